if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the architectural PC and issues single-outstanding requests to the instruction memory port with a req/ack handshake. It presents `{pc, inst, valid}` to IF/ID, absorbs downstream stalls with a one-entry skid buffer, and handles branch redirects that arrive while a fetch is in flight.

## Interface
- `RESET_PC`, default `32'h8000_0000`: PC of the first fetch after reset.
- `clk_i`  in  1  system clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `stall_i`  in  1  downstream cannot accept; the output slot is consumed on every cycle with `!stall_i`.
- `br_taken_i`  in  1  redirect request from EX.
- `br_target_i`  in  `RegW`  redirect PC, sampled when `br_taken_i` is 1.
- `inst_req_o`  out  1  fetch request.
- `inst_addr_o`  out  `RegW`  fetch address; stable while `inst_req_o` is 1 and not yet acked.
- `inst_ack_i`  in  1  memory accepts the request and returns `inst_rdata_i` in this cycle; same-cycle ack is allowed.
- `inst_rdata_i`  in  `RegW`  fetched instruction, valid only with `inst_ack_i`.
- `if_pc_o`  out  `RegW`  PC of the presented instruction; drives `if_pc_i` of IF/ID.
- `if_inst_o`  out  `RegW`  presented instruction.
- `if_valid_o`  out  1  output slot holds a real instruction.

## Operation
- Registers:
  - `pc`: next address to fetch.
  - `req_addr`: address of the in-flight request.
  - Output slot: `if_pc_o`, `if_inst_o`, `if_valid_o`.
  - Skid entry: `sk_pc`, `sk_inst`.
  - FSM state.
- Reset: `pc=RESET_PC`, state FETCH, `if_valid_o=0`, `if_pc_o=0`, `if_inst_o=0`, skid cleared. `inst_req_o` is 0 while `rst_i` is high.
- Slot free this cycle when `!if_valid_o || !stall_i`.
- FETCH: `inst_req_o=1`, `inst_addr_o=pc`, `req_addr<=pc`.
  - `br_taken_i`: `pc<=br_target_i`, `if_valid_o<=0`.
    - With ack: data dropped; stay in FETCH.
    - Without ack: go to DROP.
  - Ack, no redirect, slot free: load the slot with `{pc, inst_rdata_i}`, set `if_valid_o<=1`, `pc<=pc+4`, stay in FETCH.
  - Ack, no redirect, slot busy: capture the skid entry, `pc<=pc+4`, go to SKID.
  - No ack, no redirect: if the slot is consumed, `if_valid_o<=0`.
- SKID: `inst_req_o=0`.
  - `br_taken_i`: discard the skid entry, `if_valid_o<=0`, `pc<=br_target_i`, go to FETCH.
  - Else if `!stall_i`: move the skid entry into the slot, go to FETCH.
  - Else hold.
- DROP: `inst_req_o=1`, `inst_addr_o=req_addr`; the stale request is held until it is acked.
  - On ack: discard the data, go to FETCH.
  - A new `br_taken_i` in DROP updates `pc` only.
  - `if_valid_o` stays 0.
- Priority: redirect > stall > normal load. Redirect in the same cycle as stall flushes the slot regardless of `stall_i`.
- Arithmetic: `pc+4` is modulo 2^`RegW` (`32'hFFFF_FFFC` wraps to 0). No alignment check; `br_target_i` is used as given.

## Timing
- Zero-wait memory (ack in the request cycle): one instruction per cycle. The instruction for PC p is on `if_*_o` the cycle after p is requested.
- N-cycle ack delay: the slot is valid the cycle after the ack; throughput is one instruction per (N+1) cycles.
- Redirect at cycle t:
  - Request of `br_target_i` begins at t+1 (from FETCH or SKID), or the cycle after the stale ack (from DROP).
  - `if_valid_o=0` from t+1 until the target instruction is loaded.
- Stall: the slot and the skid entry are held unchanged. At most one request completes while the slot is stalled, after which `inst_req_o` drops.
- Reset mid-request: the pending ack is ignored. The fetch restarts at `RESET_PC` the cycle after `rst_i` falls; no handshake state survives reset.

## Test plan
- Reset release, zero-wait memory returning `inst=addr^32'hA5A5_A5A5`:
  - `inst_addr_o` = `80000000`, `80000004`, `80000008` on consecutive cycles.
  - `if_pc_o` follows one cycle later with `if_valid_o=1`.
- `stall_i` held for 3 cycles while the slot holds `80000004`:
  - One more ack (`80000008`) lands in the skid; `inst_req_o=0` for the remaining stall cycles.
  - After release, `if_pc_o` shows `80000004` then `80000008`, with no loss and no duplicate.
- Ack delayed 2 cycles: `inst_addr_o` is held stable for 3 cycles and the slot is valid the cycle after the ack.
- `br_taken_i`, target `80000100`, with no ack in that cycle (2-cycle latency):
  - `inst_addr_o` stays at the stale address until the ack, and that data is dropped.
  - Next request is `80000100`; `if_valid_o=0` throughout.
- `br_taken_i`, target `80000040`, asserted in the same cycle as `stall_i` while in SKID:
  - Slot and skid are both flushed.
  - Next valid output has `if_pc_o=80000040`.
- `RESET_PC=32'hFFFF_FFFC`: the second fetch address is `00000000` (wrap).

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the architectural PC, issues single-outstanding
// req/ack fetches and presents {pc, inst, valid} to the IF/ID register. A
// one-entry skid buffer absorbs the fetch that completes after a stall begins,
// and DROP swallows a stale fetch that was in flight when a redirect arrived.
module if_fetch #(
  parameter int              RegW     = 32,
  parameter logic [RegW-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            br_taken_i,
  input  logic [RegW-1:0] br_target_i,
  output logic            inst_req_o,
  output logic [RegW-1:0] inst_addr_o,
  input  logic            inst_ack_i,
  input  logic [RegW-1:0] inst_rdata_i,
  output logic [RegW-1:0] if_pc_o,
  output logic [RegW-1:0] if_inst_o,
  output logic            if_valid_o
);

  typedef enum logic [1:0] {FETCH, SKID, DROP} state_t;

  state_t          state, state_n;
  logic [RegW-1:0] pc;
  logic [RegW-1:0] req_addr;
  logic [RegW-1:0] sk_pc;
  logic [RegW-1:0] sk_inst;
  logic            slot_free;

  // Output slot can take new data when empty or drained this cycle.
  assign slot_free = !if_valid_o || !stall_i;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= FETCH;
    else       state <= state_n;
  end

  // Next-state and memory request; DROP replays the stale address until acked.
  always_comb begin
    state_n     = state;
    inst_req_o  = 1'b0;
    inst_addr_o = pc;
    case (state)
      FETCH: begin
        inst_req_o = 1'b1;
        if (br_taken_i && !inst_ack_i)                  state_n = DROP;
        else if (!br_taken_i && inst_ack_i && !slot_free) state_n = SKID;
      end
      SKID: begin
        if (br_taken_i || !stall_i) state_n = FETCH;
      end
      DROP: begin
        inst_req_o  = 1'b1;
        inst_addr_o = req_addr;
        if (inst_ack_i) state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase
    // No handshake may start while reset is held.
    if (rst_i) inst_req_o = 1'b0;
  end

  // PC, output slot and skid entry; redirect beats stall beats normal load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc         <= RESET_PC;
      req_addr   <= '0;
      if_valid_o <= 1'b0;
      if_pc_o    <= '0;
      if_inst_o  <= '0;
      sk_pc      <= '0;
      sk_inst    <= '0;
    end else begin
      case (state)
        FETCH: begin
          req_addr <= pc;
          if (br_taken_i) begin
            // Same-cycle ack data belongs to the wrong path and is discarded.
            pc         <= br_target_i;
            if_valid_o <= 1'b0;
          end else if (inst_ack_i) begin
            pc <= pc + RegW'(4);
            if (slot_free) begin
              if_pc_o    <= pc;
              if_inst_o  <= inst_rdata_i;
              if_valid_o <= 1'b1;
            end else begin
              sk_pc   <= pc;
              sk_inst <= inst_rdata_i;
            end
          end else if (slot_free) begin
            if_valid_o <= 1'b0;
          end
        end
        SKID: begin
          if (br_taken_i) begin
            pc         <= br_target_i;
            if_valid_o <= 1'b0;
            sk_pc      <= '0;
            sk_inst    <= '0;
          end else if (!stall_i) begin
            if_pc_o    <= sk_pc;
            if_inst_o  <= sk_inst;
            if_valid_o <= 1'b1;
          end
        end
        DROP: begin
          // Slot stays empty; a later redirect just retargets the next fetch.
          if (br_taken_i) pc <= br_target_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed walk through the fetch scenarios followed by a
// randomized run. Expected deliveries come from a program-order stream model:
// instructions leave the stage in sequence from the current stream head, and a
// redirect (or reset) restarts the stream at its target.
module tb_if_fetch;

  localparam logic [31:0] K      = 32'hA5A5_A5A5;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, stall = 1'b0, br = 1'b0, ack_en = 1'b0;
  logic [31:0] tgt = '0;

  logic        req0, ack0, valid0;
  logic [31:0] addr0, rdata0, pc0, inst0;

  assign ack0   = req0 & ack_en;
  assign rdata0 = ack0 ? (addr0 ^ K) : 32'hDEAD_BEEF;

  if_fetch #(.RegW(32), .RESET_PC(RST_PC)) u0 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .br_taken_i(br),
    .br_target_i(tgt), .inst_req_o(req0), .inst_addr_o(addr0),
    .inst_ack_i(ack0), .inst_rdata_i(rdata0), .if_pc_o(pc0),
    .if_inst_o(inst0), .if_valid_o(valid0)
  );

  // Second instance: zero-wait memory, reset PC at the top of the address space.
  logic        req1, ack1, valid1;
  logic        stall1 = 1'b0, br1 = 1'b0;
  logic [31:0] tgt1 = '0;
  logic [31:0] addr1, rdata1, pc1, inst1;

  assign ack1   = req1;
  assign rdata1 = addr1 ^ K;

  if_fetch #(.RegW(32), .RESET_PC(32'hFFFF_FFFC)) u1 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall1), .br_taken_i(br1),
    .br_target_i(tgt1), .inst_req_o(req1), .inst_addr_o(addr1),
    .inst_ack_i(ack1), .inst_rdata_i(rdata1), .if_pc_o(pc1),
    .if_inst_o(inst1), .if_valid_o(valid1)
  );

  int n_cmp = 0;
  int n_err = 0;
  int deliveries = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected PCs in delivery order.
  logic [31:0] exp_q[$];
  logic [31:0] nxt = RST_PC;
  logic        last_rst = 1'b1, last_br = 1'b0;
  logic [31:0] last_tgt = '0;

  // One clock of stimulus. The stream restart for a redirect/reset issued in
  // the previous cycle is applied here, after the monitor has already popped
  // any instruction consumed in that same cycle.
  task automatic step(input logic r, input logic s, input logic b,
                      input logic [31:0] t, input logic a);
    @(posedge clk);
    if (last_rst) begin
      exp_q.delete();
      nxt = RST_PC;
    end else if (last_br) begin
      exp_q.delete();
      nxt = last_tgt;
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back(nxt);
      nxt = nxt + 32'd4;
    end
    #1;
    rst = r; stall = s; br = b; tgt = t; ack_en = a;
    last_rst = r; last_br = b; last_tgt = t;
    #1;
  endtask

  // Monitor: pops on every consumed instruction and checks handshake rules.
  logic [31:0] e;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = '0;
  int          stall_acks = 0;

  always @(negedge clk) begin
    if (!rst && valid0 && !stall) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL deliv_unexpected: got pc %h, expected no delivery", pc0);
      end else begin
        e = exp_q.pop_front();
        check("deliv_pc", pc0, e);
        check("deliv_inst", inst0, e ^ K);
        deliveries++;
      end
    end
    if (!rst && prev_hold && req0) check("addr_stable", addr0, prev_addr);
    prev_hold = !rst && req0 && !ack0;
    prev_addr = addr0;
    if (!rst && valid0 && stall && !br) begin
      if (ack0) begin
        stall_acks++;
        n_cmp++;
        if (stall_acks > 1) begin
          n_err++;
          $display("FAIL stall_single_ack: got %0d acks in one stall, expected at most 1", stall_acks);
        end
      end
    end else begin
      stall_acks = 0;
    end
  end

  initial begin
    // Reset state
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    check("rst_req", req0, 0);
    check("rst_valid", valid0, 0);
    check("rst_pc", pc0, 0);
    check("rst_inst", inst0, 0);

    // Zero-wait fetch after reset release (and wrap on u1)
    step(0, 0, 0, 0, 1);                          // c0
    check("c0_req", req0, 1);
    check("c0_addr", addr0, 32'h8000_0000);
    check("c0_valid", valid0, 0);
    check("wrap_addr0", addr1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1);                          // c1
    check("c1_addr", addr0, 32'h8000_0004);
    check("c1_valid", valid0, 1);
    check("c1_pc", pc0, 32'h8000_0000);
    check("wrap_addr1", addr1, 32'h0000_0000);
    check("wrap_pc", pc1, 32'hFFFF_FFFC);
    check("wrap_inst", inst1, 32'hFFFF_FFFC ^ K);
    check("wrap_valid", valid1, 1);

    // Stall for 3 cycles while the slot holds 80000004
    step(0, 1, 0, 0, 1);                          // c2
    check("c2_addr", addr0, 32'h8000_0008);
    check("c2_pc", pc0, 32'h8000_0004);
    step(0, 1, 0, 0, 1);                          // c3
    check("c3_req", req0, 0);
    check("c3_pc", pc0, 32'h8000_0004);
    step(0, 1, 0, 0, 1);                          // c4
    check("c4_req", req0, 0);
    step(0, 0, 0, 0, 1);                          // c5
    check("c5_pc", pc0, 32'h8000_0004);
    check("c5_valid", valid0, 1);

    // Ack delayed 2 cycles
    step(0, 0, 0, 0, 0);                          // c6
    check("c6_pc", pc0, 32'h8000_0008);
    check("c6_addr", addr0, 32'h8000_000C);
    step(0, 0, 0, 0, 0);                          // c7
    check("c7_addr", addr0, 32'h8000_000C);
    check("c7_valid", valid0, 0);
    step(0, 0, 0, 0, 1);                          // c8
    check("c8_addr", addr0, 32'h8000_000C);
    check("c8_valid", valid0, 0);

    // Redirect to 80000100 without ack; stale fetch acked 2 cycles later
    step(0, 0, 1, 32'h8000_0100, 0);              // c9
    check("c9_valid", valid0, 1);
    check("c9_pc", pc0, 32'h8000_000C);
    step(0, 0, 0, 0, 0);                          // c10
    check("c10_addr", addr0, 32'h8000_0010);
    check("c10_req", req0, 1);
    check("c10_valid", valid0, 0);
    step(0, 0, 0, 0, 1);                          // c11
    check("c11_addr", addr0, 32'h8000_0010);
    check("c11_valid", valid0, 0);
    step(0, 0, 0, 0, 1);                          // c12
    check("c12_addr", addr0, 32'h8000_0100);
    check("c12_valid", valid0, 0);

    // Redirect together with stall while in SKID
    step(0, 1, 0, 0, 1);                          // c13
    check("c13_pc", pc0, 32'h8000_0100);
    check("c13_addr", addr0, 32'h8000_0104);
    step(0, 1, 1, 32'h8000_0040, 0);              // c14
    check("c14_req", req0, 0);
    step(0, 0, 0, 0, 1);                          // c15
    check("c15_valid", valid0, 0);
    check("c15_addr", addr0, 32'h8000_0040);
    step(0, 0, 0, 0, 0);                          // c16
    check("c16_valid", valid0, 1);
    check("c16_pc", pc0, 32'h8000_0040);

    // Reset with a request pending
    step(0, 0, 0, 0, 0);                          // c17
    step(1, 0, 0, 0, 1);                          // c18
    check("c18_req", req0, 0);
    step(0, 0, 0, 0, 1);                          // c19
    check("c19_addr", addr0, RST_PC);
    check("c19_valid", valid0, 0);
    step(0, 0, 0, 0, 1);
    check("c20_pc", pc0, RST_PC);

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      logic r, s, b, a;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 9) < 3);
      b = !r && ($urandom_range(0, 19) == 0);
      a = ($urandom_range(0, 9) < 6);
      step(r, s, b, $urandom(), a);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

    n_cmp++;
    if (deliveries < 300) begin
      n_err++;
      $display("FAIL throughput: got %0d deliveries, expected at least 300", deliveries);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
